// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU constants and fetch FSM state encoding
package fetch_stage_pkg;
  localparam int PC_W_DEF = 9;
  localparam int RESET_PC_DEF = 0;
  localparam logic [31:0] NOP_INS = 32'h0;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, instruction-memory driver and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run_i,
  input  logic            pc_load_i,
  input  logic [PC_W-1:0] pc_load_val_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] imem_addr_o,
  output logic            imem_en_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     if_ins_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic            if_valid_o,
  output logic            busy_o
);
  state_e state;
  logic [PC_W-1:0] pc_q, rsp_pc;
  logic rsp_v, req_v, redir, en;
  always_comb begin
    redir = redirect_i && state != IDLE;
    req_v = state == FETCH && !redirect_i;
    en = state == FETCH && (!stall_i || redirect_i);
  end
  assign imem_addr_o = pc_q;
  assign imem_en_o = en;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc_q <= RESET_PC;
      rsp_v <= 1'b0;
      rsp_pc <= '0;
      if_ins_o <= NOP_INS;
      if_pc_o <= '0;
      if_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_v <= 1'b0;
          if (pc_load_i) pc_q <= pc_load_val_i;
          if (run_i) state <= FETCH;
        end
        FETCH: begin
          // a redirect always forces an enabled cycle, so en covers both paths
          if (en) begin
            rsp_v <= req_v;
            rsp_pc <= pc_q;
            pc_q <= redir ? redirect_pc_i : pc_q + PC_W'(1);
          end
          if (!run_i) state <= DRAIN;
        end
        DRAIN: begin
          if (redir || !stall_i) rsp_v <= 1'b0;
          if (redir) pc_q <= redirect_pc_i;
          if (!rsp_v && !(stall_i && if_valid_o)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (redir) begin
        if_valid_o <= 1'b0;
        if_ins_o <= NOP_INS;
      end else if (!stall_i) begin
        if_ins_o <= rsp_v ? imem_rdata_i : NOP_INS;
        if_pc_o <= rsp_pc;
        if_valid_o <= rsp_v;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: program-order scoreboard plus directed timing checks for fetch_stage
module tb_fetch_stage;
  localparam int PW = 9;
  logic clk = 1'b0, reset_n = 1'b0, run_i = 1'b0, pc_load_i = 1'b0, stall_i = 1'b0, redirect_i = 1'b0;
  logic [PW-1:0] pc_load_val_i = '0, redirect_pc_i = '0, imem_addr_o, if_pc_o;
  logic imem_en_o, if_valid_o, busy_o;
  logic [31:0] imem_rdata_i, if_ins_o;
  logic [31:0] mem [1<<PW];
  int n_cmp = 0, n_bad = 0;
  logic [PW-1:0] exp_pc = '0, p_tgt, p_val, p_pc;
  logic p_stall, p_redir, p_busy, p_load, p_valid;
  logic [31:0] p_ins;

  fetch_stage #(.PC_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .run_i(run_i), .pc_load_i(pc_load_i),
    .pc_load_val_i(pc_load_val_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_en_o(imem_en_o),
    .imem_rdata_i(imem_rdata_i), .if_ins_o(if_ins_o), .if_pc_o(if_pc_o),
    .if_valid_o(if_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en_o) imem_rdata_i <= mem[imem_addr_o];

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: delivered instructions must follow program order from the
  // last reset/load/redirect, each carrying mem[pc], with stalls as pure holds.
  task automatic model_check();
    if (!reset_n) exp_pc = '0;
    else if (p_redir && p_busy) begin
      ck("m_squash_v", if_valid_o, 0);
      ck("m_squash_ins", if_ins_o, 0);
      exp_pc = p_tgt;
    end else if (p_stall) begin
      ck("m_hold_ins", if_ins_o, p_ins);
      ck("m_hold_pc", if_pc_o, p_pc);
      ck("m_hold_v", if_valid_o, p_valid);
    end else if (if_valid_o) begin
      ck("m_pc", if_pc_o, exp_pc);
      ck("m_ins", if_ins_o, 32'hA000_0000 + 32'(exp_pc));
      exp_pc = exp_pc + 1'b1;
    end else ck("m_bubble", if_ins_o, 0);
    if (reset_n && p_load) exp_pc = p_val;
  endtask

  task automatic cyc();
    p_stall = stall_i; p_redir = redirect_i; p_tgt = redirect_pc_i; p_busy = busy_o;
    p_load = pc_load_i && !busy_o; p_val = pc_load_val_i;
    p_ins = if_ins_o; p_pc = if_pc_o; p_valid = if_valid_o;
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<PW); i++) mem[i] = 32'hA000_0000 + i;
    #1;
    ck("rst_valid", if_valid_o, 0); ck("rst_ins", if_ins_o, 0); ck("rst_pc", if_pc_o, 0);
    ck("rst_busy", busy_o, 0); ck("rst_en", imem_en_o, 0); ck("rst_addr", imem_addr_o, 0);
    cyc(); cyc();
    reset_n = 1; run_i = 1;
    cyc(); ck("fetch_busy", busy_o, 1); ck("lat_v0", if_valid_o, 0);
    cyc(); ck("lat_v1", if_valid_o, 0);
    cyc(); ck("first_v", if_valid_o, 1); ck("first_pc", if_pc_o, 0); ck("first_ins", if_ins_o, 32'hA000_0000);
    for (int k = 1; k <= 3; k++) begin cyc(); ck("seq_pc", if_pc_o, k); end
    cyc(); cyc(); ck("pre_stall_pc", if_pc_o, 5);
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      cyc(); ck("stall_pc", if_pc_o, 5); ck("stall_ins", if_ins_o, 32'hA000_0005);
    end
    stall_i = 0;
    cyc(); ck("post_stall_pc6", if_pc_o, 6); ck("post_stall_v", if_valid_o, 1);
    cyc(); ck("post_stall_pc7", if_pc_o, 7);
    cyc(); ck("pre_redir_pc", if_pc_o, 8);
    redirect_i = 1; redirect_pc_i = 9'h040;
    cyc(); redirect_i = 0; ck("redir_v0", if_valid_o, 0); ck("redir_ins0", if_ins_o, 0);
    cyc(); ck("redir_v1", if_valid_o, 0);
    cyc(); ck("redir_tgt_v", if_valid_o, 1); ck("redir_tgt_pc", if_pc_o, 'h40); ck("redir_tgt_ins", if_ins_o, 32'hA000_0040);
    cyc(); ck("redir_next_pc", if_pc_o, 'h41);
    redirect_i = 1; redirect_pc_i = 9'h080; stall_i = 1;
    cyc(); redirect_i = 0; ck("rs_v0", if_valid_o, 0);
    cyc(); cyc(); ck("rs_held_v", if_valid_o, 0);
    stall_i = 0;
    cyc(); ck("rs_rel_v", if_valid_o, 0);
    cyc(); ck("rs_tgt_v", if_valid_o, 1); ck("rs_tgt_pc", if_pc_o, 'h80); ck("rs_tgt_ins", if_ins_o, 32'hA000_0080);
    run_i = 0;
    cyc(); ck("drain_pc0", if_pc_o, 'h81); ck("drain_busy0", busy_o, 1);
    cyc(); ck("drain_last_pc", if_pc_o, 'h82); ck("drain_last_v", if_valid_o, 1);
    cyc(); ck("drain_v", if_valid_o, 0); ck("drain_busy", busy_o, 0); ck("resume_addr", imem_addr_o, 'h83);
    run_i = 1;
    cyc(); cyc(); cyc(); ck("resume_pc", if_pc_o, 'h83); ck("resume_v", if_valid_o, 1);
    cyc(); cyc();
    run_i = 0;
    for (int i = 0; i < 8 && busy_o; i++) cyc();
    ck("stop_idle", busy_o, 0);
    pc_load_i = 1; pc_load_val_i = 9'h1FE; run_i = 1;
    cyc(); pc_load_i = 0; ck("load_addr", imem_addr_o, 'h1FE);
    cyc(); cyc(); ck("wrap_pc0", if_pc_o, 'h1FE); ck("wrap_ins0", if_ins_o, 32'hA000_01FE);
    cyc(); ck("wrap_pc1", if_pc_o, 'h1FF);
    cyc(); ck("wrap_pc2", if_pc_o, 'h000); ck("wrap_ins2", if_ins_o, 32'hA000_0000);
    cyc(); cyc();
    reset_n = 0; #1;
    ck("arst_valid", if_valid_o, 0); ck("arst_ins", if_ins_o, 0); ck("arst_pc", if_pc_o, 0);
    ck("arst_busy", busy_o, 0); ck("arst_en", imem_en_o, 0);
    cyc(); reset_n = 1;
    cyc(); cyc(); cyc(); ck("rerun_pc", if_pc_o, 0); ck("rerun_v", if_valid_o, 1);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
